pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter register and next-PC sequencer for the simplified multicycle 16-bit RISC-V core.
- Sits directly upstream of the PC adder, drives its A/B/Cin operands and consumes its Sum.
- Owns the instruction-fetch handshake with instruction memory. Holds PC and OldPC (address of the instruction in execution).
- Applies the redirect (sequential, branch, jump, trap) commanded by the main controller.

Parameters:
- WIDTH, 16, PC / address width
- RESET_PC, 16'h0000, PC value loaded on reset
- PC_INC, 16'h0001, sequential increment (word-addressed instruction memory)
- TRAP_VEC, 16'h00F0, PC loaded on trap redirect

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- AddA  out  WIDTH  adder operand A (combinational)
- AddB  out  WIDTH  adder operand B (combinational)
- AddCin  out  1  adder carry-in, always 0
- AddSum  in  WIDTH  adder result (combinational from AddA/AddB)
- IMemReq  out  1  fetch request
- IMemAddr  out  WIDTH  fetch address, equals PC
- IMemAck  in  1  memory has returned the instruction this cycle
- InstrValid  out  1  one-cycle pulse: fetched instruction latched downstream, OldPC valid
- PCWrite  in  1  controller commits next PC
- PCSrc  in  2  00 seq, 01 branch, 10 jump, 11 trap
- Offset  in  WIDTH  signed branch offset
- Target  in  WIDTH  absolute jump target (ALU result)
- Halt  in  1  stop fetching, qualified by PCWrite
- PC  out  WIDTH  current PC register
- OldPC  out  WIDTH  PC of the instruction currently executing
- Halted  out  1  sequencer parked in HALT

Behaviour:
- One clock domain. Reset is asynchronous and active-low. Asserting rst_n=0 immediately forces:
  - state=IDLE, PC=RESET_PC, OldPC=RESET_PC
  - InstrValid=0, Halted=0, IMemReq=0
- This applies at any time, including mid-fetch.
- FSM states: IDLE, FETCH, EXEC, HALT.
- IDLE: IMemReq=0. Goes to FETCH unconditionally on the next edge.
- FETCH:
  - IMemReq=1, IMemAddr=PC. Adder mux: AddA=PC, AddB=PC_INC.
  - On IMemAck=1 at an edge: OldPC<=PC, PC<=AddSum, InstrValid<=1 for exactly the next cycle, go to EXEC.
  - Without ack: hold all registers and keep requesting, with no timeout.
- EXEC:
  - IMemReq=0. Adder mux: AddA=OldPC, AddB=Offset, giving the branch target.
  - Waits indefinitely for PCWrite. On PCWrite=1:
    - PCSrc=00: PC unchanged (already OldPC+PC_INC).
    - PCSrc=01: PC<=AddSum.
    - PCSrc=10: PC<=Target.
    - PCSrc=11: PC<=TRAP_VEC.
  - Next state is HALT if Halt=1, else FETCH. The PC update is still applied when halting.
- HALT: Halted=1, IMemReq=0. Adder mux: AddA=PC, AddB=0. Exits only via reset.
- IDLE uses the same adder mux as HALT: AddA=PC, AddB=0. AddCin=0 in every state.
- Ignored inputs:
  - PCWrite, PCSrc and Halt are ignored outside EXEC.
  - IMemAck is ignored outside FETCH.
  - Halt without PCWrite is ignored.
- Arithmetic: modulo 2^WIDTH, carry out discarded. 16'hFFFF+1 = 16'h0000. Negative Offset is two's complement, so OldPC=0x0010 with Offset=0xFFF8 gives 0x0008.
- Minimum instruction period is 2 cycles (FETCH with immediate ack, then EXEC with immediate PCWrite). InstrValid pulses are never back-to-back.
- Registered outputs: PC, OldPC, InstrValid, Halted. Combinational outputs: IMemReq, IMemAddr, AddA, AddB.

Test Plan:
- Reset release, IMemAck tied 1, PCWrite tied 1, PCSrc=00 -> IMemAddr sequence 0000, 0001, 0002, 0003 on alternate cycles; InstrValid pulses every other cycle; OldPC trails PC by 1.
- FETCH with IMemAck delayed 3 cycles -> IMemReq held high 4 cycles, IMemAddr stable, PC unchanged until the ack edge.
- Branch: OldPC=0x0010, Offset=0xFFF8, PCSrc=01 -> next IMemAddr=0x0008. Jump: Target=0x1234, PCSrc=10 -> 0x1234. Trap: PCSrc=11 -> 0x00F0.
- Wrap: PC=0xFFFF fetched and acked, PCSrc=00 -> PC=0x0000, next fetch address 0x0000.
- Ignored events: PCWrite=1 during FETCH and IMemAck=1 during EXEC -> no state or PC change. Halt=1 without PCWrite -> stays in EXEC.
- Halt=1 with PCWrite=1 and PCSrc=10, Target=0x0040 -> PC=0x0040, Halted=1, IMemReq stays 0 forever. rst_n pulsed low mid-FETCH -> IMemReq drops in the same cycle and PC=0x0000.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter register and next-PC sequencer for the multicycle 16-bit core.
// Drives the shared PC adder, owns the fetch handshake and applies controller redirects.
module pc_sequencer #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = 16'h0000,
  parameter logic [WIDTH-1:0] PC_INC   = 16'h0001,
  parameter logic [WIDTH-1:0] TRAP_VEC = 16'h00F0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] AddA,
  output logic [WIDTH-1:0] AddB,
  output logic             AddCin,
  input  logic [WIDTH-1:0] AddSum,
  output logic             IMemReq,
  output logic [WIDTH-1:0] IMemAddr,
  input  logic             IMemAck,
  output logic             InstrValid,
  input  logic             PCWrite,
  input  logic [1:0]       PCSrc,
  input  logic [WIDTH-1:0] Offset,
  input  logic [WIDTH-1:0] Target,
  input  logic             Halt,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] OldPC,
  output logic             Halted
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] old_pc_q, old_pc_d;
  logic             instr_valid_q, instr_valid_d;
  logic             halted_q, halted_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      old_pc_q      <= RESET_PC;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      old_pc_q      <= old_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    old_pc_d      = old_pc_q;
    instr_valid_d = 1'b0;
    halted_d      = halted_q;
    IMemReq       = 1'b0;
    AddA          = pc_q;
    AddB          = '0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        IMemReq = 1'b1;
        AddB    = PC_INC;
        if (IMemAck) begin
          old_pc_d      = pc_q;
          pc_d          = AddSum;
          instr_valid_d = 1'b1;
          state_d       = S_EXEC;
        end
      end
      S_EXEC: begin
        // Adder is free during EXEC, so it computes the branch target off OldPC.
        AddA = old_pc_q;
        AddB = Offset;
        if (PCWrite) begin
          unique case (PCSrc)
            2'b00: pc_d = pc_q;
            2'b01: pc_d = AddSum;
            2'b10: pc_d = Target;
            2'b11: pc_d = TRAP_VEC;
          endcase
          state_d  = Halt ? S_HALT : S_FETCH;
          halted_d = Halt;
        end
      end
      S_HALT: halted_d = 1'b1;
    endcase
  end

  assign AddCin     = 1'b0;
  assign IMemAddr   = pc_q;
  assign PC         = pc_q;
  assign OldPC      = old_pc_q;
  assign InstrValid = instr_valid_q;
  assign Halted     = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic checked
// every cycle against a phase-level model of the sequencer.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] AddA, AddB, AddSum, IMemAddr, Offset, Target, PC, OldPC;
  logic        AddCin, IMemReq, IMemAck, InstrValid, PCWrite, Halt, Halted;
  logic [1:0]  PCSrc;

  int total = 0;
  int bad   = 0;

  // model: phase 0 idle, 1 fetch, 2 exec, 3 halt
  int          m_phase;
  logic [15:0] m_pc, m_old;
  logic        m_iv, m_halted;

  always #5 clk = ~clk;

  assign AddSum = AddA + AddB + {15'b0, AddCin};

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .AddA(AddA), .AddB(AddB), .AddCin(AddCin),
    .AddSum(AddSum), .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck),
    .InstrValid(InstrValid), .PCWrite(PCWrite), .PCSrc(PCSrc), .Offset(Offset),
    .Target(Target), .Halt(Halt), .PC(PC), .OldPC(OldPC), .Halted(Halted)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_pc = 16'h0000; m_old = 16'h0000; m_iv = 1'b0; m_halted = 1'b0;
  endtask

  task automatic compare_model();
    logic [15:0] exp_a, exp_b;
    exp_a = (m_phase == 2) ? m_old : m_pc;
    exp_b = (m_phase == 1) ? 16'h0001 : (m_phase == 2) ? Offset : 16'h0000;
    chk("m_pc", PC, m_pc);
    chk("m_oldpc", OldPC, m_old);
    chk("m_instrvalid", {15'b0, InstrValid}, {15'b0, m_iv});
    chk("m_halted", {15'b0, Halted}, {15'b0, m_halted});
    chk("m_imemreq", {15'b0, IMemReq}, {15'b0, m_phase == 1});
    chk("m_imemaddr", IMemAddr, m_pc);
    chk("m_adda", AddA, exp_a);
    chk("m_addb", AddB, exp_b);
    chk("m_addcin", {15'b0, AddCin}, 16'h0000);
  endtask

  // One clock: drive at negedge, check, advance model across the posedge.
  task automatic cycle(input logic a, input logic pw, input logic [1:0] s,
                       input logic [15:0] o, input logic [15:0] t, input logic h);
    int          n_phase;
    logic [15:0] n_pc, n_old;
    logic        n_iv;
    @(negedge clk);
    IMemAck = a; PCWrite = pw; PCSrc = s; Offset = o; Target = t; Halt = h;
    #1;
    compare_model();
    n_phase = m_phase; n_pc = m_pc; n_old = m_old; n_iv = 1'b0;
    if (m_phase == 0) n_phase = 1;
    else if (m_phase == 1 && a) begin
      n_old = m_pc; n_pc = m_pc + 16'd1; n_iv = 1'b1; n_phase = 2;
    end else if (m_phase == 2 && pw) begin
      case (s)
        2'b00: n_pc = m_pc;
        2'b01: n_pc = m_old + o;
        2'b10: n_pc = t;
        default: n_pc = 16'h00F0;
      endcase
      n_phase = h ? 3 : 1;
    end
    @(posedge clk);
    m_phase = n_phase; m_pc = n_pc; m_old = n_old; m_iv = n_iv; m_halted = (n_phase == 3);
    #1;
  endtask

  task automatic check_reset_now();
    chk("rst_pc", PC, 16'h0000);
    chk("rst_oldpc", OldPC, 16'h0000);
    chk("rst_imemreq", {15'b0, IMemReq}, 16'h0000);
    chk("rst_instrvalid", {15'b0, InstrValid}, 16'h0000);
    chk("rst_halted", {15'b0, Halted}, 16'h0000);
  endtask

  // Asserts reset partway into a low clock phase, checks it took effect at once.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_now();
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  initial begin
    IMemAck = 0; PCWrite = 0; PCSrc = 0; Offset = 0; Target = 0; Halt = 0;
    model_reset();
    #1 check_reset_now();
    @(posedge clk);
    #2 rst_n = 1'b1;

    // sequential run with ack and PCWrite tied high
    for (int i = 0; i < 8; i++) cycle(1, 1, 2'b00, 16'h0, 16'h0, 0);
    chk("seq_pc", PC, 16'h0004);
    chk("seq_oldpc", OldPC, 16'h0003);
    chk("seq_iv", {15'b0, InstrValid}, 16'h0001);

    // delayed ack
    cycle(0, 1, 2'b00, 16'h0, 16'h0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 2'b00, 16'h0, 16'h0, 0);
    chk("wait_pc", PC, 16'h0004);
    chk("wait_req", {15'b0, IMemReq}, 16'h0001);
    cycle(1, 0, 2'b00, 16'h0, 16'h0, 0);
    chk("ack_pc", PC, 16'h0005);

    // jump to 0x0010, then backwards branch
    cycle(0, 1, 2'b10, 16'h0, 16'h0010, 0);
    cycle(1, 0, 2'b00, 16'h0, 16'h0, 0);
    chk("br_oldpc", OldPC, 16'h0010);
    cycle(0, 1, 2'b01, 16'hFFF8, 16'h0, 0);
    chk("br_addr", IMemAddr, 16'h0008);
    cycle(1, 0, 2'b00, 16'h0, 16'h0, 0);
    cycle(0, 1, 2'b10, 16'h0, 16'h1234, 0);
    chk("jmp_addr", IMemAddr, 16'h1234);
    cycle(1, 0, 2'b00, 16'h0, 16'h0, 0);
    cycle(0, 1, 2'b11, 16'h0, 16'h0, 0);
    chk("trap_addr", IMemAddr, 16'h00F0);
    cycle(1, 0, 2'b00, 16'h0, 16'h0, 0);

    // wrap at 0xFFFF
    cycle(0, 1, 2'b10, 16'h0, 16'hFFFF, 0);
    cycle(1, 0, 2'b00, 16'h0, 16'h0, 0);
    chk("wrap_pc", PC, 16'h0000);
    chk("wrap_oldpc", OldPC, 16'hFFFF);
    cycle(0, 1, 2'b00, 16'h0, 16'h0, 0);
    chk("wrap_addr", IMemAddr, 16'h0000);

    // ignored events
    cycle(0, 1, 2'b10, 16'h0, 16'h5555, 1);
    chk("ign_pcw_pc", PC, 16'h0000);
    cycle(1, 0, 2'b00, 16'h0, 16'h0, 0);
    cycle(1, 0, 2'b00, 16'h0, 16'h0, 0);
    chk("ign_ack_pc", PC, 16'h0001);
    chk("ign_ack_iv", {15'b0, InstrValid}, 16'h0000);
    cycle(0, 0, 2'b10, 16'h0, 16'h7777, 1);
    chk("ign_halt_req", {15'b0, IMemReq}, 16'h0000);
    chk("ign_halt_hd", {15'b0, Halted}, 16'h0000);
    cycle(0, 1, 2'b00, 16'h0, 16'h0, 0);
    chk("ign_halt_fetch", {15'b0, IMemReq}, 16'h0001);

    // halt with jump
    cycle(1, 0, 2'b00, 16'h0, 16'h0, 0);
    cycle(0, 1, 2'b10, 16'h0, 16'h0040, 1);
    chk("halt_pc", PC, 16'h0040);
    chk("halt_hd", {15'b0, Halted}, 16'h0001);
    for (int i = 0; i < 6; i++) cycle(1, 1, 2'b01, 16'h0003, 16'h0100, 0);
    chk("halt_req", {15'b0, IMemReq}, 16'h0000);

    // reset mid-fetch
    do_reset();
    cycle(0, 0, 2'b00, 16'h0, 16'h0, 0);
    cycle(1, 0, 2'b00, 16'h0, 16'h0, 0);
    cycle(0, 1, 2'b10, 16'h0, 16'h0077, 0);
    chk("pre_rst_addr", IMemAddr, 16'h0077);
    chk("pre_rst_req", {15'b0, IMemReq}, 16'h0001);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499, 0) == 0) do_reset();
      else cycle($urandom_range(2, 0) != 0, $urandom_range(2, 0) != 0,
                 2'($urandom_range(3, 0)), 16'($urandom), 16'($urandom),
                 $urandom_range(59, 0) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
